// File: rtl/exp_result_serializer.sv
// rtl/exp_result_serializer.sv - buffers 128-bit power-of-8 results and streams them as 32-bit beats
//
// Purpose:
//   Each i_valid pulse delivers one DATA_W result from the power-of-8 stage.
//   Results are held in a DEPTH-entry FIFO and sent out as BEATS words of
//   WORD_W bits, least-significant word first, over a valid/ready handshake.
//   Upstream cannot be stalled, so a result arriving at a full FIFO with no
//   pop in the same cycle is discarded and a sticky overflow flag is raised.
//
// Ports:
//   i_clk          clock, all state on the rising edge
//   i_reset        asynchronous, active-high reset
//   i_data         result from the power-of-8 stage
//   i_valid        i_data valid this cycle (one result per high cycle)
//   o_word         current output word (0 when the FIFO is empty)
//   o_word_valid   o_word valid
//   i_word_ready   consumer accepts o_word this cycle
//   o_last         o_word is the final beat of a result
//   o_count        entries held, 0..DEPTH
//   o_full         o_count == DEPTH
//   o_overflow     sticky: a result was dropped since reset

module exp_result_serializer #(
    parameter int DATA_W = 128,
    parameter int WORD_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic [DATA_W-1:0]        i_data,
    input  logic                     i_valid,
    output logic [WORD_W-1:0]        o_word,
    output logic                     o_word_valid,
    input  logic                     i_word_ready,
    output logic                     o_last,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_overflow
);

    localparam int BEATS  = DATA_W / WORD_W;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEATS - 1);

    typedef enum logic {
        S_EMPTY  = 1'b0,
        S_STREAM = 1'b1
    } state_t;

    state_t              state;
    state_t              state_nxt;

    logic [DATA_W-1:0]   mem [DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CNT_W-1:0]    count;
    logic [CNT_W-1:0]    count_nxt;
    logic [BEAT_W-1:0]   beat;
    logic [BEAT_W-1:0]   beat_nxt;
    logic                overflow;

    logic                word_valid;
    logic                last_beat;
    logic                xfer;
    logic                pop;
    logic                wr_en;
    logic                drop;

    logic [WORD_W-1:0]   head_words [BEATS];

    // ------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------
    always_comb begin
        word_valid = (state == S_STREAM);
        last_beat  = word_valid && (beat == BEAT_LAST);
        xfer       = word_valid && i_word_ready;
        pop        = xfer && last_beat;
        // A pop frees the head slot at the same edge, so a full FIFO can
        // still take the incoming result when the last beat leaves.
        wr_en      = i_valid && ((count < CNT_FULL) || pop);
        drop       = i_valid && !wr_en;
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        count_nxt = count;
        beat_nxt  = beat;

        unique case ({wr_en, pop})
            2'b10:   count_nxt = count + CNT_ONE;
            2'b01:   count_nxt = count - CNT_ONE;
            default: count_nxt = count;
        endcase

        if (pop) begin
            beat_nxt = '0;
        end else if (xfer) begin
            beat_nxt = beat + BEAT_W'(1);
        end

        unique case (state)
            S_EMPTY: begin
                if (wr_en) begin
                    state_nxt = S_STREAM;
                end
            end
            S_STREAM: begin
                if (pop && (count == CNT_ONE) && !wr_en) begin
                    state_nxt = S_EMPTY;
                end
            end
            default: state_nxt = S_EMPTY;
        endcase
    end

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state    <= S_EMPTY;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            beat     <= '0;
            overflow <= 1'b0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            beat  <= beat_nxt;
            // DEPTH is a power of two, so natural pointer wrap is mod DEPTH.
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Result storage. Contents are only observed while count > 0, and every
    // visible slot has been written first, so the array carries no reset.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= i_data;
        end
    end

    // ------------------------------------------------------------------
    // Output word select: purely from stored state, never from i_data.
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < BEATS; i++) begin
            head_words[i] = mem[rd_ptr][i*WORD_W +: WORD_W];
        end
    end

    always_comb begin
        o_word = '0;
        if (count != '0) begin
            o_word = head_words[beat];
        end
    end

    assign o_word_valid = word_valid;
    assign o_last       = last_beat;
    assign o_count      = count;
    assign o_full       = (count == CNT_FULL);
    assign o_overflow   = overflow;

endmodule

// File: tb/tb_exp_result_serializer.sv
// tb/tb_exp_result_serializer.sv - directed self-checking bench for exp_result_serializer

module tb_exp_result_serializer;

    logic         i_clk;
    logic         i_reset;
    logic [127:0] i_data;
    logic         i_valid;
    logic [31:0]  o_word;
    logic         o_word_valid;
    logic         i_word_ready;
    logic         o_last;
    logic [2:0]   o_count;
    logic         o_full;
    logic         o_overflow;

    int n_cmp  = 0;
    int n_fail = 0;

    exp_result_serializer #(
        .DATA_W (128),
        .WORD_W (32),
        .DEPTH  (4)
    ) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_data       (i_data),
        .i_valid      (i_valid),
        .o_word       (o_word),
        .o_word_valid (o_word_valid),
        .i_word_ready (i_word_ready),
        .o_last       (o_last),
        .o_count      (o_count),
        .o_full       (o_full),
        .o_overflow   (o_overflow)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    function automatic logic [127:0] pow8(input logic [127:0] x);
        logic [127:0] r;
        r = 128'd1;
        for (int k = 0; k < 8; k++) r = r * x;
        return r;
    endfunction

    // Checks all outputs are at their reset/idle value.
    task automatic check_idle(input string tag);
        n_cmp++;
        if (o_word_valid !== 1'b0 || o_word !== 32'd0 || o_last !== 1'b0 ||
            o_count !== 3'd0 || o_full !== 1'b0) begin
            n_fail++;
            $display("FAIL %s idle: valid=%b word=%h last=%b count=%0d full=%b, required 0/0/0/0/0",
                     tag, o_word_valid, o_word, o_last, o_count, o_full);
        end
    endtask

    // Called at a negedge with ready held high and the head result at beat 0.
    // Checks the four beats and returns at the negedge after the last beat.
    task automatic check_stream(input string tag, input logic [127:0] data);
        logic [31:0] exp_w;
        for (int b = 0; b < 4; b++) begin
            exp_w = data[b*32 +: 32];
            n_cmp++;
            if (o_word_valid !== 1'b1 || o_word !== exp_w || o_last !== (b == 3)) begin
                n_fail++;
                $display("FAIL %s beat%0d: valid=%b word=%h last=%b, required 1/%h/%b",
                         tag, b, o_word_valid, o_word, o_last, exp_w, (b == 3));
            end
            @(negedge i_clk);
        end
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        i_valid = 1'b0;
        i_word_ready = 1'b0;
        i_data = '0;
        @(negedge i_clk);
        @(negedge i_clk);
        check_idle("reset");
        n_cmp++;
        if (o_overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL reset overflow: got %b, required 0", o_overflow);
        end
        i_reset = 1'b0;
        @(negedge i_clk);
    endtask

    task automatic write_one(input logic [127:0] data);
        i_valid = 1'b1;
        i_data  = data;
        @(negedge i_clk);
        i_valid = 1'b0;
    endtask

    task automatic test_single();
        i_word_ready = 1'b1;
        write_one(pow8(128'd2));
        n_cmp++;
        if (o_count !== 3'd1) begin
            n_fail++;
            $display("FAIL single count: got %0d, required 1", o_count);
        end
        check_stream("single256", 128'd256);
        check_idle("single_after");
    endtask

    task automatic test_big();
        i_word_ready = 1'b1;
        write_one(pow8(128'd65535));
        check_stream("big65535", pow8(128'd65535));
        check_idle("big_after");
    endtask

    task automatic test_overflow();
        i_word_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            i_valid = 1'b1;
            i_data  = pow8(128'(k));
            @(negedge i_clk);
        end
        i_valid = 1'b0;
        n_cmp++;
        if (o_count !== 3'd4 || o_full !== 1'b1 || o_overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow flags: count=%0d full=%b ovf=%b, required 4/1/1",
                     o_count, o_full, o_overflow);
        end
        // Stalled: head beat 0 of 1^8 is presented and held.
        @(negedge i_clk);
        n_cmp++;
        if (o_word_valid !== 1'b1 || o_word !== 32'd1 || o_last !== 1'b0) begin
            n_fail++;
            $display("FAIL overflow stall: valid=%b word=%h last=%b, required 1/00000001/0",
                     o_word_valid, o_word, o_last);
        end
        i_word_ready = 1'b1;
        for (int k = 1; k <= 4; k++) check_stream("ovf_drain", pow8(128'(k)));
        check_idle("ovf_after");
        n_cmp++;
        if (o_overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow sticky: got %b, required 1", o_overflow);
        end
    endtask

    task automatic test_full_write();
        logic [31:0] exp_w;
        i_word_ready = 1'b0;
        for (int k = 6; k <= 9; k++) begin
            i_valid = 1'b1;
            i_data  = pow8(128'(k));
            @(negedge i_clk);
        end
        i_valid = 1'b0;
        n_cmp++;
        if (o_count !== 3'd4 || o_full !== 1'b1 || o_overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL fullwr pre: count=%0d full=%b ovf=%b, required 4/1/0",
                     o_count, o_full, o_overflow);
        end
        i_word_ready = 1'b1;
        for (int b = 0; b < 4; b++) begin
            exp_w = pow8(128'd6) >> (b * 32);
            n_cmp++;
            if (o_word !== exp_w || o_last !== (b == 3)) begin
                n_fail++;
                $display("FAIL fullwr head beat%0d: word=%h last=%b, required %h/%b",
                         b, o_word, o_last, exp_w, (b == 3));
            end
            if (b == 3) begin
                i_valid = 1'b1;
                i_data  = pow8(128'd10);
            end
            @(negedge i_clk);
        end
        i_valid = 1'b0;
        n_cmp++;
        if (o_count !== 3'd4 || o_full !== 1'b1 || o_overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL fullwr post: count=%0d full=%b ovf=%b, required 4/1/0",
                     o_count, o_full, o_overflow);
        end
        for (int k = 7; k <= 10; k++) check_stream("fullwr_drain", pow8(128'(k)));
        check_idle("fullwr_after");
    endtask

    task automatic test_random_ready();
        logic [127:0] q[$];
        logic [127:0] d;
        logic [31:0]  exp_w;
        logic [31:0]  prev_word;
        logic         prev_last;
        logic         prev_stalled;
        logic         rdy;
        logic         wv;
        logic         mvalid;
        logic         pop;
        logic         was_full;
        int           mbeat;
        int           issued;
        int           cyc;
        mbeat = 0;
        issued = 0;
        cyc = 0;
        prev_stalled = 1'b0;
        prev_word = '0;
        prev_last = 1'b0;
        while ((issued < 20 || q.size() > 0) && cyc < 2000) begin
            mvalid = (q.size() > 0);
            n_cmp++;
            if (o_word_valid !== mvalid || o_count !== 3'(q.size())) begin
                n_fail++;
                $display("FAIL rand cyc%0d state: valid=%b count=%0d, required %b/%0d",
                         cyc, o_word_valid, o_count, mvalid, q.size());
            end
            if (mvalid) begin
                exp_w = q[0] >> (mbeat * 32);
                n_cmp++;
                if (o_word !== exp_w || o_last !== (mbeat == 3)) begin
                    n_fail++;
                    $display("FAIL rand cyc%0d word: word=%h last=%b, required %h/%b",
                             cyc, o_word, o_last, exp_w, (mbeat == 3));
                end
            end
            if (prev_stalled) begin
                n_cmp++;
                if (o_word !== prev_word || o_last !== prev_last) begin
                    n_fail++;
                    $display("FAIL rand cyc%0d stall hold: word=%h last=%b, required %h/%b",
                             cyc, o_word, o_last, prev_word, prev_last);
                end
            end
            rdy = ($urandom_range(0, 3) != 0);
            i_word_ready = rdy;
            wv = ((cyc % 6) == 0) && (issued < 20);
            d = {$urandom(), $urandom(), $urandom(), $urandom()};
            i_valid = wv;
            i_data  = d;
            if (wv) issued++;
            was_full = (q.size() == 4);
            pop = mvalid && rdy && (mbeat == 3);
            if (mvalid && rdy) mbeat = pop ? 0 : mbeat + 1;
            if (pop) void'(q.pop_front());
            if (wv && (!was_full || pop)) q.push_back(d);
            prev_stalled = mvalid && !rdy;
            prev_word = o_word;
            prev_last = o_last;
            @(negedge i_clk);
            cyc++;
        end
        i_valid = 1'b0;
        i_word_ready = 1'b1;
        n_cmp++;
        if (cyc >= 2000) begin
            n_fail++;
            $display("FAIL rand timeout: cycles=%0d queued=%0d, required drain before 2000",
                     cyc, q.size());
        end
    endtask

    task automatic test_reset_mid();
        logic [127:0] a;
        logic [127:0] d;
        a = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
        d = 128'hdead_beef_0000_1111_2222_3333_4444_5555;
        i_word_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            i_valid = 1'b1;
            i_data  = a + 128'(k);
            @(negedge i_clk);
        end
        i_valid = 1'b0;
        i_word_ready = 1'b1;
        @(negedge i_clk);
        @(negedge i_clk);
        n_cmp++;
        if (o_word !== a[95:64] || o_count !== 3'd3) begin
            n_fail++;
            $display("FAIL midrst beat2: word=%h count=%0d, required %h/3",
                     o_word, o_count, a[95:64]);
        end
        i_reset = 1'b1;
        #1;
        check_idle("midrst_async");
        n_cmp++;
        if (o_overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst overflow: got %b, required 0", o_overflow);
        end
        @(negedge i_clk);
        i_reset = 1'b0;
        @(negedge i_clk);
        check_idle("midrst_released");
        write_one(d);
        check_stream("midrst_restart", d);
        check_idle("midrst_after");
    endtask

    initial begin
        i_reset = 1'b1;
        i_valid = 1'b0;
        i_word_ready = 1'b0;
        i_data = '0;
        @(negedge i_clk);
        test_reset();
        test_single();
        test_big();
        test_overflow();
        test_reset();
        test_full_write();
        test_random_ready();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
